// File: rtl/ddr_app_arbiter_pkg.sv
// Shared constants and state encoding for the MIG app-interface arbiter.
package ddr_app_arbiter_pkg;

  localparam logic [2:0]  APP_CMD_WR        = 3'b000;
  localparam logic [2:0]  APP_CMD_RD        = 3'b001;
  localparam int unsigned DDR_APP_ADDR_W    = 28;
  localparam int unsigned DDR_APP_DATA_W    = 128;
  localparam int unsigned DDR_APP_LEN_W     = 4;
  localparam int unsigned DDR_APP_ADDR_STEP = 8;

  typedef enum logic [2:0] {
    StIdle,
    StRdCmd,
    StRdWait,
    StWr,
    StDone
  } arb_state_e;

endpackage

// File: rtl/ddr_rr_arb2.sv
// Two-way round-robin picker. pref_q names the port that wins a tie; it moves to the
// other port each time a pick is taken, so port 0 wins the first tie after reset.
module ddr_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       take_i,
  output logic       gnt_vld_o,
  output logic       gnt_idx_o
);

  logic pref_q;

  // Combinational pick: a lone requester wins, a tie goes to the preferred port.
  always_comb begin
    gnt_vld_o = |req_i;
    gnt_idx_o = 1'b0;
    unique case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = pref_q;
      default: gnt_idx_o = 1'b0;
    endcase
  end

  // Hand preference to the loser whenever a grant is actually taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pref_q <= 1'b0;
    end else if (take_i) begin
      pref_q <= ~gnt_idx_o;
    end
  end

endmodule

// File: rtl/ddr_app_arbiter.sv
// Shares the MIG 7-series app_* interface between the L2 (port 0) and DFC (port 1)
// burst requesters: one burst at a time, round-robin, per-beat commands under app_rdy,
// write data under app_wdf_rdy, read beats routed back to the owning port.
module ddr_app_arbiter
  import ddr_app_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = DDR_APP_ADDR_W,
  parameter int unsigned DATA_W    = DDR_APP_DATA_W,
  parameter int unsigned LEN_W     = DDR_APP_LEN_W,
  parameter int unsigned ADDR_STEP = DDR_APP_ADDR_STEP
) (
  input  logic                clk_166M66,
  input  logic                mcu_sys_rst,
  input  logic                i_init_calib_complete,
  input  logic                i_p0_req,
  input  logic                i_p0_rw,
  input  logic [ADDR_W-1:0]   i_p0_addr,
  input  logic [LEN_W-1:0]    i_p0_len,
  output logic                o_p0_gnt,
  input  logic [DATA_W-1:0]   i_p0_wdata,
  output logic                o_p0_wdata_pop,
  output logic                o_p0_rdata_vld,
  output logic                o_p0_done,
  input  logic                i_p1_req,
  input  logic                i_p1_rw,
  input  logic [ADDR_W-1:0]   i_p1_addr,
  input  logic [LEN_W-1:0]    i_p1_len,
  output logic                o_p1_gnt,
  input  logic [DATA_W-1:0]   i_p1_wdata,
  output logic                o_p1_wdata_pop,
  output logic                o_p1_rdata_vld,
  output logic                o_p1_done,
  output logic [DATA_W-1:0]   o_rdata,
  output logic [ADDR_W-1:0]   o_app_addr,
  output logic [2:0]          o_app_cmd,
  output logic                o_app_en,
  input  logic                i_app_rdy,
  output logic [DATA_W-1:0]   o_app_wdf_data,
  output logic                o_app_wdf_wren,
  output logic                o_app_wdf_end,
  output logic [DATA_W/8-1:0] o_app_wdf_mask,
  input  logic                i_app_wdf_rdy,
  input  logic [DATA_W-1:0]   i_app_rd_data,
  input  logic                i_app_rd_data_valid
);

  // Counters hold 0..2^LEN_W, so one extra bit over the length field.
  localparam int unsigned CntW = LEN_W + 1;

  arb_state_e        state_q;
  logic              owner_q;
  logic [CntW-1:0]   beats_q;
  logic [CntW-1:0]   cmd_cnt_q;
  logic [CntW-1:0]   wdat_cnt_q;
  logic [CntW-1:0]   rd_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        cmd_q;
  logic              en_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;

  logic              arb_vld;
  logic              arb_idx;
  logic              arb_take;

  logic              cmd_acc;
  logic              rd_beat;
  logic              wren;
  logic              wpop;
  logic [CntW-1:0]   cmd_cnt_nxt;
  logic [CntW-1:0]   rd_cnt_nxt;
  logic [CntW-1:0]   wdat_cnt_nxt;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [LEN_W-1:0]  sel_len;

  ddr_rr_arb2 u_rr_arb2 (
    .clk_i     (clk_166M66),
    .rst_i     (mcu_sys_rst),
    .req_i     ({i_p1_req, i_p0_req}),
    .take_i    (arb_take),
    .gnt_vld_o (arb_vld),
    .gnt_idx_o (arb_idx)
  );

  // Arbitration is frozen until calibration is done and only runs from idle.
  assign arb_take = (state_q == StIdle) & i_init_calib_complete & arb_vld;

  // Beat handshakes and next counter values shared by the FSM and the outputs.
  always_comb begin
    cmd_acc      = en_q & i_app_rdy;
    rd_beat      = i_app_rd_data_valid & ((state_q == StRdCmd) | (state_q == StRdWait));
    wren         = (state_q == StWr) & (wdat_cnt_q < beats_q);
    wpop         = wren & i_app_wdf_rdy;
    cmd_cnt_nxt  = cmd_cnt_q + CntW'(cmd_acc);
    rd_cnt_nxt   = rd_cnt_q + CntW'(rd_beat);
    wdat_cnt_nxt = wdat_cnt_q + CntW'(wpop);
    sel_rw       = arb_idx ? i_p1_rw   : i_p0_rw;
    sel_addr     = arb_idx ? i_p1_addr : i_p0_addr;
    sel_len      = arb_idx ? i_p1_len  : i_p0_len;
  end

  // Burst sequencer: grant capture, command issue, beat counting and completion.
  always_ff @(posedge clk_166M66 or posedge mcu_sys_rst) begin
    if (mcu_sys_rst) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      beats_q    <= '0;
      cmd_cnt_q  <= '0;
      wdat_cnt_q <= '0;
      rd_cnt_q   <= '0;
      addr_q     <= '0;
      cmd_q      <= '0;
      en_q       <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      if (rd_beat) rd_cnt_q <= rd_cnt_nxt;
      if (wpop) wdat_cnt_q <= wdat_cnt_nxt;
      if (cmd_acc) begin
        // Address wraps modulo 2^ADDR_W by truncation.
        addr_q    <= addr_q + ADDR_W'(ADDR_STEP);
        cmd_cnt_q <= cmd_cnt_nxt;
        if (cmd_cnt_nxt == beats_q) en_q <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (arb_take) begin
            owner_q         <= arb_idx;
            beats_q         <= {1'b0, sel_len} + CntW'(1);
            addr_q          <= sel_addr;
            cmd_q           <= sel_rw ? APP_CMD_RD : APP_CMD_WR;
            en_q            <= 1'b1;
            cmd_cnt_q       <= '0;
            wdat_cnt_q      <= '0;
            rd_cnt_q        <= '0;
            gnt_q[arb_idx]  <= 1'b1;
            state_q         <= sel_rw ? StRdCmd : StWr;
          end
        end
        StRdCmd: begin
          if (cmd_acc && (cmd_cnt_nxt == beats_q)) state_q <= StRdWait;
        end
        StRdWait: begin
          if (rd_cnt_nxt == beats_q) begin
            state_q         <= StDone;
            done_q[owner_q] <= 1'b1;
          end
        end
        StWr: begin
          if ((cmd_cnt_nxt == beats_q) && (wdat_cnt_nxt == beats_q)) begin
            state_q         <= StDone;
            done_q[owner_q] <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_p0_gnt       = gnt_q[0];
  assign o_p1_gnt       = gnt_q[1];
  assign o_p0_done      = done_q[0];
  assign o_p1_done      = done_q[1];
  assign o_app_addr     = addr_q;
  assign o_app_cmd      = cmd_q;
  assign o_app_en       = en_q;
  assign o_app_wdf_wren = wren;
  assign o_app_wdf_end  = wren;
  assign o_app_wdf_mask = '0;
  assign o_app_wdf_data = wren ? (owner_q ? i_p1_wdata : i_p0_wdata) : '0;
  assign o_p0_wdata_pop = wpop & ~owner_q;
  assign o_p1_wdata_pop = wpop & owner_q;
  assign o_p0_rdata_vld = rd_beat & ~owner_q;
  assign o_p1_rdata_vld = rd_beat & owner_q;
  assign o_rdata        = rd_beat ? i_app_rd_data : '0;

endmodule

// File: tb/tb_ddr_app_arbiter.sv
// Directed bench for ddr_app_arbiter: a table of single-port bursts plus hand-written
// sequences for calibration gating, app_rdy stalls, mid-burst reset and round-robin.
module tb_ddr_app_arbiter;
  import ddr_app_arbiter_pkg::*;

  localparam int AW = 28;
  localparam int DW = 128;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          calib;
  logic          p0_req, p0_rw, p0_gnt, p0_pop, p0_vld, p0_done;
  logic [AW-1:0] p0_addr;
  logic [LW-1:0] p0_len;
  logic [DW-1:0] p0_wdata;
  logic          p1_req, p1_rw, p1_gnt, p1_pop, p1_vld, p1_done;
  logic [AW-1:0] p1_addr;
  logic [LW-1:0] p1_len;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] rdata;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy;
  logic [DW-1:0] wdf_data;
  logic          wdf_wren, wdf_end, wdf_rdy;
  logic [DW/8-1:0] wdf_mask;
  logic [DW-1:0] rd_data;
  logic          rd_valid;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit            port;
    bit            rw;
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    logic [AW-1:0] exp_a0;
    logic [AW-1:0] exp_alast;
    int            exp_beats;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  ddr_app_arbiter dut (
    .clk_166M66            (clk),
    .mcu_sys_rst           (rst),
    .i_init_calib_complete (calib),
    .i_p0_req              (p0_req),
    .i_p0_rw               (p0_rw),
    .i_p0_addr             (p0_addr),
    .i_p0_len              (p0_len),
    .o_p0_gnt              (p0_gnt),
    .i_p0_wdata            (p0_wdata),
    .o_p0_wdata_pop        (p0_pop),
    .o_p0_rdata_vld        (p0_vld),
    .o_p0_done             (p0_done),
    .i_p1_req              (p1_req),
    .i_p1_rw               (p1_rw),
    .i_p1_addr             (p1_addr),
    .i_p1_len              (p1_len),
    .o_p1_gnt              (p1_gnt),
    .i_p1_wdata            (p1_wdata),
    .o_p1_wdata_pop        (p1_pop),
    .o_p1_rdata_vld        (p1_vld),
    .o_p1_done             (p1_done),
    .o_rdata               (rdata),
    .o_app_addr            (app_addr),
    .o_app_cmd             (app_cmd),
    .o_app_en              (app_en),
    .i_app_rdy             (app_rdy),
    .o_app_wdf_data        (wdf_data),
    .o_app_wdf_wren        (wdf_wren),
    .o_app_wdf_end         (wdf_end),
    .o_app_wdf_mask        (wdf_mask),
    .i_app_wdf_rdy         (wdf_rdy),
    .i_app_rd_data         (rd_data),
    .i_app_rd_data_valid   (rd_valid)
  );

  function automatic logic [DW-1:0] mk(input int t, input int i);
    return {32'(t), 32'hC0DE_0000, 32'(i), 32'(i) ^ 32'h5A5A_5A5A};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit p, input bit r, input bit rw, input logic [AW-1:0] a,
                         input logic [LW-1:0] l);
    if (!p) begin
      p0_req = r; p0_rw = rw; p0_addr = a; p0_len = l;
    end else begin
      p1_req = r; p1_rw = rw; p1_addr = a; p1_len = l;
    end
  endtask

  // Waits up to mx cycles for gnt (kind 0) or done (kind 1) on port p; ends at posedge+1.
  task automatic wait_evt(input bit p, input int kind, input int mx, output bit seen);
    bit s;
    seen = 1'b0;
    for (int i = 0; i < mx; i++) begin
      @(negedge clk);
      if (kind == 0) s = p ? p1_gnt : p0_gnt;
      else           s = p ? p1_done : p0_done;
      @(posedge clk); #1;
      if (s) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Runs one burst end to end, acting as the requester and as the MIG.
  task automatic run_burst(input vec_t v, input int tag);
    int acc, beats, pops, dones, gnts, wrong, pend, rdi;
    logic [AW-1:0] a0, alast;
    logic [2:0] exp_cmd;
    logic my_g, oth_g, my_pop, oth_pop, my_vld, oth_vld, my_done, oth_done;
    acc = 0; beats = 0; pops = 0; dones = 0; gnts = 0; wrong = 0; pend = 0; rdi = 0;
    a0 = '0; alast = '0;
    exp_cmd = v.rw ? APP_CMD_RD : APP_CMD_WR;
    @(posedge clk); #1;
    set_req(v.port, 1'b1, v.rw, v.addr, v.len);
    app_rdy = 1'b1; wdf_rdy = 1'b1; rd_valid = 1'b0;
    if (!v.port) p0_wdata = mk(0, 0); else p1_wdata = mk(1, 0);
    for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
      @(negedge clk);
      my_g     = v.port ? p1_gnt  : p0_gnt;   oth_g    = v.port ? p0_gnt  : p1_gnt;
      my_pop   = v.port ? p1_pop  : p0_pop;   oth_pop  = v.port ? p0_pop  : p1_pop;
      my_vld   = v.port ? p1_vld  : p0_vld;   oth_vld  = v.port ? p0_vld  : p1_vld;
      my_done  = v.port ? p1_done : p0_done;  oth_done = v.port ? p0_done : p1_done;
      if (my_g) gnts++;
      if (oth_g) wrong++;
      if (app_en && app_rdy) begin
        if (acc == 0) a0 = app_addr;
        alast = app_addr;
        if (app_cmd !== exp_cmd) wrong++;
        acc++;
        if (v.rw) pend++;
      end
      if (wdf_end !== wdf_wren || wdf_mask !== '0) wrong++;
      if (my_pop !== (wdf_wren & wdf_rdy) || oth_pop) wrong++;
      if (wdf_wren && wdf_rdy) begin
        if (wdf_data !== mk(v.port, pops)) wrong++;
        pops++;
      end
      if (rd_valid) begin
        if (!my_vld || oth_vld || rdata !== mk(2, beats)) wrong++;
        beats++;
      end else if (my_vld || oth_vld) begin
        wrong++;
      end
      if (my_done) dones++;
      if (oth_done) wrong++;
      @(posedge clk); #1;
      if (gnts > 0) set_req(v.port, 1'b0, v.rw, v.addr, v.len);
      app_rdy = (cyc % 3) != 1;
      wdf_rdy = (cyc % 2) == 1;
      if (!v.port) p0_wdata = mk(0, pops); else p1_wdata = mk(1, pops);
      if (v.rw && pend > 0 && (cyc % 2) == 0) begin
        rd_valid = 1'b1; rd_data = mk(2, rdi); rdi++; pend--;
      end else begin
        rd_valid = 1'b0;
      end
    end
    set_req(v.port, 1'b0, 1'b0, '0, '0);
    rd_valid = 1'b0; app_rdy = 1'b1; wdf_rdy = 1'b1;
    chk($sformatf("v%0d_gnt", tag), gnts, 1);
    chk($sformatf("v%0d_cmds", tag), acc, v.exp_beats);
    chk($sformatf("v%0d_addr_first", tag), a0, v.exp_a0);
    chk($sformatf("v%0d_addr_last", tag), alast, v.exp_alast);
    chk($sformatf("v%0d_data_beats", tag), v.rw ? beats : pops, v.exp_beats);
    chk($sformatf("v%0d_done", tag), dones, 1);
    chk($sformatf("v%0d_proto_errs", tag), wrong, 0);
  endtask

  initial begin
    bit seen;
    int bad, stale;
    int gq[$];

    vecs[0] = '{1'b0, 1'b1, 28'h000_0100, 4'd3,  28'h000_0100, 28'h000_0118, 4};
    vecs[1] = '{1'b1, 1'b0, 28'hFFF_FFF8, 4'd1,  28'hFFF_FFF8, 28'h000_0000, 2};
    vecs[2] = '{1'b1, 1'b1, 28'h000_2000, 4'd0,  28'h000_2000, 28'h000_2000, 1};
    vecs[3] = '{1'b0, 1'b0, 28'h000_0040, 4'd15, 28'h000_0040, 28'h000_00B8, 16};
    vecs[4] = '{1'b0, 1'b1, 28'hFFF_FFF0, 4'd3,  28'hFFF_FFF0, 28'h000_0008, 4};

    rst = 1'b1; calib = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    p0_wdata = '0; p1_wdata = '0; app_rdy = 1'b0; wdf_rdy = 1'b0;
    rd_data = '0; rd_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_app_en", app_en, 0);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_gnt", {p0_gnt, p1_gnt}, 0);
    chk("rst_wren", wdf_wren, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Calibration gating: request held, nothing may happen until calib rises.
    set_req(1'b0, 1'b1, vecs[0].rw, vecs[0].addr, vecs[0].len);
    app_rdy = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (p0_gnt || p1_gnt || app_en) bad++;
    end
    chk("calib_low_quiet", bad, 0);
    calib = 1'b1;

    for (int i = 0; i < 5; i++) run_burst(vecs[i], i);

    // app_rdy stall: command must hold while rdy is low, then advance once per accept.
    set_req(1'b0, 1'b1, 1'b1, 28'h000_0500, 4'd1);
    app_rdy = 1'b0;
    wait_evt(1'b0, 0, 10, seen);
    chk("stall_gnt", seen, 1);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      repeat (5) begin
        @(negedge clk);
        if (!app_en || app_addr !== 28'(28'h500 + 8 * k) || app_cmd !== APP_CMD_RD) bad++;
        @(posedge clk); #1;
      end
      app_rdy = 1'b1;
      @(negedge clk);
      chk($sformatf("stall_acc%0d_en", k), app_en, 1);
      chk($sformatf("stall_acc%0d_addr", k), app_addr, 28'h500 + 8 * k);
      @(posedge clk); #1;
      app_rdy = 1'b0;
    end
    @(negedge clk);
    chk("stall_en_off", app_en, 0);
    chk("stall_held_errs", bad, 0);
    @(posedge clk); #1;
    bad = 0;
    for (int b = 0; b < 2; b++) begin
      rd_valid = 1'b1; rd_data = mk(2, b);
      @(negedge clk);
      if (!p0_vld || p1_vld || rdata !== mk(2, b)) bad++;
      @(posedge clk); #1;
    end
    rd_valid = 1'b0; app_rdy = 1'b1;
    chk("stall_rd_errs", bad, 0);
    wait_evt(1'b0, 1, 10, seen);
    chk("stall_done", seen, 1);

    // Reset in the middle of a 4-beat read after 2 beats returned.
    set_req(1'b0, 1'b1, 1'b1, 28'h000_0800, 4'd3);
    wait_evt(1'b0, 0, 10, seen);
    chk("mrst_gnt", seen, 1);
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    bad = 0;
    for (int b = 0; b < 2; b++) begin
      rd_valid = 1'b1; rd_data = mk(2, b);
      @(negedge clk);
      if (!p0_vld) bad++;
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;
    chk("mrst_first_beats", bad, 0);
    rst = 1'b1;
    #1;
    chk("mrst_app_en", app_en, 0);
    chk("mrst_app_addr", app_addr, 0);
    chk("mrst_app_cmd", app_cmd, 0);
    chk("mrst_done", {p0_done, p1_done}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    stale = 0;
    repeat (3) begin
      rd_valid = 1'b1; rd_data = mk(9, 9);
      @(negedge clk);
      if (p0_vld || p1_vld || p0_done || p1_done || rdata !== '0) stale++;
      @(posedge clk); #1;
    end
    rd_valid = 1'b0;
    chk("mrst_stale_ignored", stale, 0);
    run_burst(vecs[2], 5);

    // Round-robin: both ports request continuously, grants must alternate from port 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(1'b0, 1'b1, 1'b0, 28'h000_0010, 4'd0);
    set_req(1'b1, 1'b1, 1'b0, 28'h000_0020, 4'd0);
    app_rdy = 1'b1; wdf_rdy = 1'b1;
    bad = 0;
    for (int c = 0; c < 60 && gq.size() < 4; c++) begin
      @(negedge clk);
      if (p0_gnt && p1_gnt) bad++;
      else if (p0_gnt) gq.push_back(0);
      else if (p1_gnt) gq.push_back(1);
      @(posedge clk); #1;
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0);
    chk("rr_count", gq.size(), 4);
    chk("rr_dual_gnt", bad, 0);
    for (int i = 0; i < gq.size(); i++) chk($sformatf("rr_order%0d", i), gq[i], i % 2);
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
